// File: rtl/writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_if : ALU/LSU result inputs and register-file write port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface writeback_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pending;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready, wr_en, wr_addr, wr_data, pending
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output lsu_ready, wr_en, wr_addr, wr_data, pending
   );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_unit : arbitrates ALU and buffered LSU results onto the     |
// | register-file write port. Optional bypass outputs: WB_FORWARD_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module writeback_unit #(
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   writeback_if.slave       bus
`ifdef WB_FORWARD_EN
   ,
   input  wire logic [4:0]  fwd_rs1,
   input  wire logic [4:0]  fwd_rs2,
   output logic             fwd1_hit,
   output logic             fwd2_hit,
   output logic [31:0]      fwd1_data,
   output logic [31:0]      fwd2_data
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       buf_rd_q   [FIFO_DEPTH];
   logic [4:0]       buf_rd_d   [FIFO_DEPTH];
   logic [31:0]      buf_data_q [FIFO_DEPTH];
   logic [31:0]      buf_data_d [FIFO_DEPTH];
   logic             wr_en_q, wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [31:0]      wr_data_q, wr_data_d;
   logic [31:0]      pending_q, pending_d;
   logic [PTR_W-1:0] scan_idx;

   logic lsu_ready;
   logic alu_sel;
   logic push;
   logic pop;

   // Ready depends only on the registered count, so no input reaches it.
   assign lsu_ready = (count_q < DEPTH_CNT);
   assign alu_sel   = bus.alu_valid && (bus.alu_rd != 5'd0);
   assign push      = bus.lsu_valid && lsu_ready;
   assign pop       = !alu_sel && (count_q != '0);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      buf_rd_d   = buf_rd_q;
      buf_data_d = buf_data_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      pending_d  = '0;
      scan_idx   = '0;

      if (push) begin
         buf_rd_d[wr_ptr_q]   = bus.lsu_rd;
         buf_data_d[wr_ptr_q] = bus.lsu_data;
         wr_ptr_d             = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end

      if (alu_sel) begin
         wr_en_d   = 1'b1;
         wr_addr_d = bus.alu_rd;
         wr_data_d = bus.alu_data;
      end else if (pop) begin
         // A head beat targeting x0 consumes its slot but never writes.
         if (buf_rd_q[rd_ptr_q] != 5'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = buf_rd_q[rd_ptr_q];
            wr_data_d = buf_data_q[rd_ptr_q];
         end
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Pending mirrors the next buffer contents, which covers coincident push/pop.
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         scan_idx = rd_ptr_d + PTR_W'(k);
         if (CNT_W'(k) < count_d) begin
            pending_d[buf_rd_d[scan_idx]] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_rd_q[i]   <= '0;
            buf_data_q[i] <= '0;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         pending_q  <= pending_d;
         buf_rd_q   <= buf_rd_d;
         buf_data_q <= buf_data_d;
      end
   end

   assign bus.lsu_ready = lsu_ready;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.pending   = pending_q;

`ifdef WB_FORWARD_EN
   assign fwd1_hit  = wr_en_q && (fwd_rs1 != 5'd0) && (wr_addr_q == fwd_rs1);
   assign fwd2_hit  = wr_en_q && (fwd_rs2 != 5'd0) && (wr_addr_q == fwd_rs2);
   assign fwd1_data = fwd1_hit ? wr_data_q : 32'd0;
   assign fwd2_data = fwd2_hit ? wr_data_q : 32'd0;
`endif
endmodule
`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the long-latency result buffer; legal values 2 or 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  single-cycle result present this cycle; cannot be stalled.
REQ-005 SHALL have ports alu_rd  input  5  and  alu_data  input  32  for the destination register and data of the ALU result.
REQ-006 SHALL have port lsu_valid  input  1  long-latency (load/divide) result offered.
REQ-007 SHALL have ports lsu_rd  input  5  and  lsu_data  input  32  for the destination register and data of the offered result.
REQ-008 SHALL have port lsu_ready  output  1  result buffer can accept a beat this cycle.
REQ-009 SHALL have ports wr_en  output  1,  wr_addr  output  5  and  wr_data  output  32, which drive the register-file write port.
REQ-010 SHALL have port pending  output  32  per-register mask of results accepted but not yet written.

Function
REQ-011 An LSU beat SHALL be accepted when lsu_valid and lsu_ready are both 1 on a rising edge.
REQ-012 lsu_ready SHALL equal (buffer count < FIFO_DEPTH), decoded from registered count only, with no combinational path from any input.
REQ-013 Each cycle, one source SHALL be selected in this priority: (a) ALU if alu_valid and alu_rd != 0; else (b) the buffer head if count > 0, which is popped.
REQ-014 The selected source SHALL be registered into wr_addr/wr_data with wr_en = 1 on the next edge (latency 1 for ALU); with no selection, wr_en SHALL be 0 and wr_addr/wr_data SHALL hold their values.
REQ-015 An accepted LSU beat SHALL reach the buffer head no earlier than the following cycle; minimum accept-to-wr_en latency is 2 cycles.
REQ-016 An ALU result with alu_rd == 0 SHALL be discarded, and SHALL NOT block a buffer pop in that cycle.
REQ-017 A buffer beat with rd == 0 SHALL be popped in turn, producing wr_en = 0 for that slot.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged; buffer pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Buffer order SHALL be FIFO; results are never reordered within the LSU stream.
REQ-020 pending[r] SHALL be set on the edge accepting a beat with rd == r != 0, and cleared on the edge that pops the last buffered beat for r.
REQ-021 pending[0] SHALL always be 0.
REQ-022 If an accept and a pop for the same r coincide, pending[r] SHALL remain 1.
REQ-023 ALU writes SHALL NOT affect pending.

Reset
REQ-024 While rst_n = 0: count = 0, pointers = 0, wr_en = 0, wr_addr = 0, wr_data = 0, pending = 0, lsu_ready = 1.
REQ-025 Reset asserted mid-operation SHALL discard all buffered beats, with no write issued for them.
REQ-026 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With WB_FORWARD_EN defined, the block SHALL add inputs fwd_rs1 and fwd_rs2 (5 bits each) and outputs fwd1_hit, fwd2_hit (1 bit each) and fwd1_data, fwd2_data (32 bits each).
REQ-028 With WB_FORWARD_EN defined, fwdN_hit SHALL be 1 combinationally when wr_en = 1 and wr_addr == fwd_rsN != 0, and fwdN_data SHALL equal wr_data in that case and 0 otherwise.
REQ-029 Without WB_FORWARD_EN, those ports SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset then ALU beat (x5, 0x0000_00AA) -> next cycle wr_en = 1, wr_addr = 5, wr_data = 0xAA; pending = 0.
REQ-031 LSU beat (x7, 0x1234_5678) accepted while alu_valid = 0 -> pending[7] = 1; wr_en on 2nd cycle with wr_addr = 7; pending[7] = 0 after that pop edge.
REQ-032 FIFO_DEPTH = 2, two LSU beats (x1, x2) plus continuous ALU (x3) traffic -> lsu_ready = 0, only x3 written; ALU drops -> x1 then x2 written in order, lsu_ready returns to 1.
REQ-033 ALU beat with alu_rd = 0 while buffer holds (x9, 0xDEAD) -> x9 written next cycle; no write to x0 ever.
REQ-034 Assert rst_n = 0 with 2 beats buffered -> immediately wr_en = 0, pending = 0, lsu_ready = 1; no write for the buffered beats after release.
REQ-035 With WB_FORWARD_EN, fwd_rs1 = 5 during the wr_en cycle of REQ-030 -> fwd1_hit = 1, fwd1_data = 0xAA; fwd_rs2 = 0 -> fwd2_hit = 0.
